mem_access_unit: RTL and testbench

Memory-access (MEM) stage of the 5-stage RV32 pipeline, directly downstream of the EX/MEM pipeline registers. Turns the EX/MEM load/store controls into a request/acknowledge transaction on the data-memory port and aligns/replicates store data with byte enables. It sign- or zero-extends load data and stalls the pipeline until memory responds. Its writeback outputs feed the MEM/WB pipeline registers.

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
interface mem_access_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// RV32 MEM stage: issues data-memory transactions, aligns store data,
// extends load data and stalls the pipeline until memory acknowledges.
module mem_access_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_rs2_data,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic [2:0]  mem_mem_op_length,
   mem_access_unit_if.master dmem,
   output logic        stall,
   output logic        access_fault,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_req;
   logic              r_we;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [BE_W-1:0]   r_be;
   logic [2:0]        r_op;
   logic [1:0]        r_off;
   logic [XLEN-1:0]   r_load_data;

   logic              w_access;
   logic              w_is_load;
   logic [1:0]        w_off;
   logic              w_illegal;
   logic              w_fault;
   logic [XLEN-1:0]   w_store_wdata;
   logic [BE_W-1:0]   w_store_be;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [XLEN-1:0]   w_load_word;

   // Decode access type, legality and alignment of the EX/MEM instruction.
   always_comb begin
      w_access  = mem_mem_read | mem_mem_write;
      w_is_load = mem_mem_read & ~mem_mem_write;
      w_off     = mem_alu_result[1:0];
      w_illegal = 1'b0;
      w_fault   = 1'b0;
      case (mem_mem_op_length)
         OP_B, OP_BU: w_illegal = 1'b0;
         OP_H, OP_HU: w_fault   = w_off[0];
         OP_W:        w_fault   = (w_off != 2'b00);
         default:     w_illegal = 1'b1;
      endcase
      w_fault = w_access & (w_fault | w_illegal);
   end

   // Replicate store data across lanes and pick the byte enables for the offset.
   always_comb begin
      w_store_wdata = '0;
      w_store_be    = '0;
      case (mem_mem_op_length[1:0])
         2'b00: begin
            w_store_wdata = {4{mem_rs2_data[7:0]}};
            w_store_be    = BE_W'(4'b0001 << w_off);
         end
         2'b01: begin
            w_store_wdata = {2{mem_rs2_data[15:0]}};
            w_store_be    = w_off[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            w_store_wdata = mem_rs2_data;
            w_store_be    = 4'b1111;
         end
         default: begin
            w_store_wdata = '0;
            w_store_be    = '0;
         end
      endcase
   end

   // Select and extend the addressed byte/half of the returned read word.
   always_comb begin
      w_byte      = 8'h00;
      w_load_word = dmem.dmem_rdata;
      case (r_off)
         2'd0:    w_byte = dmem.dmem_rdata[7:0];
         2'd1:    w_byte = dmem.dmem_rdata[15:8];
         2'd2:    w_byte = dmem.dmem_rdata[23:16];
         default: w_byte = dmem.dmem_rdata[31:24];
      endcase
      w_half = r_off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      case (r_op)
         OP_B:    w_load_word = {{24{w_byte[7]}}, w_byte};
         OP_H:    w_load_word = {{16{w_half[15]}}, w_half};
         OP_BU:   w_load_word = {24'h000000, w_byte};
         OP_HU:   w_load_word = {16'h0000, w_half};
         default: w_load_word = dmem.dmem_rdata;
      endcase
   end

   // Request FSM with registered memory-port fields and captured load word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_op        <= '0;
         r_off       <= '0;
         r_load_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access && !w_fault) begin
                  r_req   <= 1'b1;
                  r_we    <= mem_mem_write;
                  r_addr  <= {mem_alu_result[31:2], 2'b00};
                  r_wdata <= mem_mem_write ? w_store_wdata : '0;
                  r_be    <= mem_mem_write ? w_store_be : '0;
                  r_op    <= mem_mem_op_length;
                  r_off   <= w_off;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (dmem.dmem_ack) begin
                  r_req       <= 1'b0;
                  r_load_data <= w_load_word;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign dmem.dmem_req   = r_req;
   assign dmem.dmem_we    = r_we;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_wdata = r_wdata;
   assign dmem.dmem_be    = r_be;

   // Pipeline-facing stall, fault and writeback, combinational from state and EX/MEM.
   always_comb begin
      stall        = reset_n & ((r_state == S_BUSY) |
                                ((r_state == S_IDLE) & w_access & ~w_fault));
      access_fault = reset_n & w_fault;
      wb_rd        = mem_rd;
      wb_data      = (w_is_load && (r_state == S_DONE)) ? r_load_data : mem_alu_result;
      wb_reg_write = mem_reg_write & ~mem_mem_write & ~w_fault &
                     (~w_is_load | (r_state == S_DONE));
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions, memory responder,
// and decoupled monitors for memory requests and instruction retirement.
module tb_mem_access_unit;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_wdata;
      logic [3:0]  be;
      int          len;
      int          gap;
   } req_exp_t;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wr;
      logic        fault;
      int          stalls;
   } ret_exp_t;

   logic        clock;
   logic        reset_n;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_rs2_data;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic        mem_mem_write;
   logic [2:0]  mem_mem_op_length;
   logic        stall;
   logic        access_fault;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;

   mem_access_unit_if dmem ();

   mem_access_unit dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .mem_alu_result    (mem_alu_result),
      .mem_rs2_data      (mem_rs2_data),
      .mem_rd            (mem_rd),
      .mem_reg_write     (mem_reg_write),
      .mem_mem_read      (mem_mem_read),
      .mem_mem_write     (mem_mem_write),
      .mem_mem_op_length (mem_mem_op_length),
      .dmem              (dmem),
      .stall             (stall),
      .access_fault      (access_fault),
      .wb_data           (wb_data),
      .wb_rd             (wb_rd),
      .wb_reg_write      (wb_reg_write)
   );

   req_exp_t req_q[$];
   ret_exp_t ret_q[$];
   int       n_cmp = 0;
   int       n_err = 0;
   logic     tb_valid = 1'b0;
   logic     resp_en = 1'b1;
   int       mem_lat = 1;
   logic [31:0] mem_rdata = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void push_req(input string name, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic chk_wdata,
                                    input logic [3:0] be, input int len, input int gap);
      req_exp_t e;
      e.name = name; e.we = we; e.addr = addr; e.wdata = wdata; e.chk_wdata = chk_wdata;
      e.be = be; e.len = len; e.gap = gap;
      req_q.push_back(e);
   endfunction

   function automatic void push_ret(input string name, input logic [31:0] data, input logic [4:0] rd,
                                    input logic wr, input logic fault, input int stalls);
      ret_exp_t e;
      e.name = name; e.data = data; e.rd = rd; e.wr = wr; e.fault = fault; e.stalls = stalls;
      ret_q.push_back(e);
   endfunction

   task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic rd_en, input logic wr_en, input logic [2:0] op);
      mem_alu_result    = alu;
      mem_rs2_data      = rs2;
      mem_rd            = rd;
      mem_reg_write     = rw;
      mem_mem_read      = rd_en;
      mem_mem_write     = wr_en;
      mem_mem_op_length = op;
   endtask

   task automatic bubble();
      drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   // Present one instruction until it retires (stall low), then advance EX/MEM.
   task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic rd_en, input logic wr_en,
                        input logic [2:0] op, input int lat, input logic [31:0] rdata);
      logic retired;
      mem_lat   = lat;
      mem_rdata = rdata;
      drive(alu, rs2, rd, rw, rd_en, wr_en, op);
      tb_valid  = 1'b1;
      retired   = 1'b0;
      for (int c = 0; c < 60 && !retired; c++) begin
         @(negedge clock);
         if (!stall) retired = 1'b1;
      end
      if (!retired) chk({name, ".retire_timeout"}, 32'd0, 32'd1);
      @(posedge clock);
      #1;
      tb_valid = 1'b0;
      bubble();
   endtask

   // Memory responder: acknowledge after mem_lat cycles of dmem_req.
   initial begin
      int busy_cnt;
      busy_cnt = 0;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = '0;
      forever begin
         @(negedge clock);
         if (resp_en) begin
            if (dmem.dmem_ack) begin
               dmem.dmem_ack = 1'b0;
               busy_cnt = 0;
            end else if (dmem.dmem_req) begin
               busy_cnt++;
               if (busy_cnt == mem_lat) begin
                  dmem.dmem_ack   = 1'b1;
                  dmem.dmem_rdata = mem_rdata;
               end
            end else begin
               busy_cnt = 0;
            end
         end
      end
   end

   // Request monitor: check fields on rising dmem_req, length on fall, gap on next rise.
   initial begin
      logic     prev_req;
      int       high_cnt;
      int       low_cnt;
      req_exp_t cur;
      logic     have_cur;
      prev_req = 1'b0; high_cnt = 0; low_cnt = 1000; have_cur = 1'b0;
      forever begin
         @(negedge clock);
         if (dmem.dmem_req && !prev_req) begin
            high_cnt = 1;
            if (req_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
               have_cur = 1'b0;
            end else begin
               cur = req_q.pop_front();
               have_cur = 1'b1;
               chk({cur.name, ".we"},   32'(dmem.dmem_we),   32'(cur.we));
               chk({cur.name, ".addr"}, dmem.dmem_addr,      cur.addr);
               chk({cur.name, ".be"},   32'(dmem.dmem_be),   32'(cur.be));
               if (cur.chk_wdata) chk({cur.name, ".wdata"}, dmem.dmem_wdata, cur.wdata);
               if (cur.gap >= 0) chk({cur.name, ".req_gap"}, 32'(low_cnt), 32'(cur.gap));
            end
         end else if (dmem.dmem_req) begin
            high_cnt++;
         end else if (prev_req) begin
            low_cnt = 1;
            if (have_cur && cur.len >= 0) chk({cur.name, ".req_len"}, 32'(high_cnt), 32'(cur.len));
            have_cur = 1'b0;
         end else begin
            low_cnt++;
         end
         prev_req = dmem.dmem_req;
      end
   end

   // Retire monitor: count stall cycles, compare writeback when the instruction leaves MEM.
   initial begin
      int       stall_cnt;
      ret_exp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clock);
         if (reset_n && tb_valid) begin
            if (stall) begin
               stall_cnt++;
            end else begin
               if (ret_q.size() == 0) begin
                  chk("unexpected_retire", 32'd1, 32'd0);
               end else begin
                  e = ret_q.pop_front();
                  chk({e.name, ".wb_data"},      wb_data,               e.data);
                  chk({e.name, ".wb_rd"},        32'(wb_rd),            32'(e.rd));
                  chk({e.name, ".wb_reg_write"}, 32'(wb_reg_write),     32'(e.wr));
                  chk({e.name, ".access_fault"}, 32'(access_fault),     32'(e.fault));
                  chk({e.name, ".stall_cycles"}, 32'(stall_cnt),        32'(e.stalls));
               end
               stall_cnt = 0;
            end
         end else begin
            stall_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      reset_n = 1'b0;
      // Misaligned LW presented during reset: fault and stall must stay low.
      drive(32'h0000_0301, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 3'b010);
      #12;
      chk("rst.dmem_req",     32'(dmem.dmem_req),   32'd0);
      chk("rst.dmem_we",      32'(dmem.dmem_we),    32'd0);
      chk("rst.dmem_addr",    dmem.dmem_addr,       32'd0);
      chk("rst.dmem_wdata",   dmem.dmem_wdata,      32'd0);
      chk("rst.dmem_be",      32'(dmem.dmem_be),    32'd0);
      chk("rst.stall",        32'(stall),           32'd0);
      chk("rst.access_fault", 32'(access_fault),    32'd0);
      bubble();
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      push_ret("alu", 32'h0000_1234, 5'd5, 1'b1, 1'b0, 0);
      issue("alu", 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1, 32'h0);

      push_req("lb", 1'b0, 32'h0000_0100, 32'h0, 1'b0, 4'b0000, 2, -1);
      push_ret("lb", 32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 3);
      issue("lb", 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 2, 32'h80FF_FF11);

      push_req("lbu", 1'b0, 32'h0000_0100, 32'h0, 1'b0, 4'b0000, 2, -1);
      push_ret("lbu", 32'h0000_0080, 5'd8, 1'b1, 1'b0, 3);
      issue("lbu", 32'h0000_0103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b100, 2, 32'h80FF_FF11);

      push_req("sh", 1'b1, 32'h0000_0200, 32'hBEEF_BEEF, 1'b1, 4'b1100, 1, -1);
      push_ret("sh", 32'h0000_0202, 5'd3, 1'b0, 1'b0, 2);
      issue("sh", 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001, 1, 32'h0);

      push_ret("lw_mis", 32'h0000_0301, 5'd4, 1'b0, 1'b1, 0);
      issue("lw_mis", 32'h0000_0301, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 1, 32'h0);

      push_ret("op011", 32'h0000_0300, 5'd4, 1'b0, 1'b1, 0);
      issue("op011", 32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b011, 1, 32'h0);

      push_ret("lh_mis", 32'h0000_0201, 5'd6, 1'b0, 1'b1, 0);
      issue("lh_mis", 32'h0000_0201, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b001, 1, 32'h0);

      push_req("lh", 1'b0, 32'h0000_0300, 32'h0, 1'b0, 4'b0000, 1, -1);
      push_ret("lh", 32'hFFFF_8001, 5'd10, 1'b1, 1'b0, 2);
      issue("lh", 32'h0000_0302, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b001, 1, 32'h8001_7FFF);

      push_req("lhu", 1'b0, 32'h0000_0304, 32'h0, 1'b0, 4'b0000, 1, -1);
      push_ret("lhu", 32'h0000_1234, 5'd11, 1'b1, 1'b0, 2);
      issue("lhu", 32'h0000_0306, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b101, 1, 32'h1234_ABCD);

      push_req("lw", 1'b0, 32'h0000_0308, 32'h0, 1'b0, 4'b0000, 3, -1);
      push_ret("lw", 32'h89AB_CDEF, 5'd12, 1'b1, 1'b0, 4);
      issue("lw", 32'h0000_0308, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010, 3, 32'h89AB_CDEF);

      push_req("sb", 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 1'b1, 4'b0010, 1, -1);
      push_ret("sb", 32'h0000_0401, 5'd0, 1'b0, 1'b0, 2);
      issue("sb", 32'h0000_0401, 32'h0000_00A5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1, 32'h0);

      // Read and write both set: the store takes precedence and nothing is written back.
      push_req("rw_both", 1'b1, 32'h0000_0600, 32'h0BAD_F00D, 1'b1, 4'b1111, 1, -1);
      push_ret("rw_both", 32'h0000_0600, 5'd13, 1'b0, 1'b0, 2);
      issue("rw_both", 32'h0000_0600, 32'h0BAD_F00D, 5'd13, 1'b1, 1'b1, 1'b1, 3'b010, 1, 32'h0);

      // Back-to-back zero-wait stores: req low in DONE and the following IDLE.
      push_req("sw1", 1'b1, 32'h0000_0500, 32'h1122_3344, 1'b1, 4'b1111, 1, -1);
      push_ret("sw1", 32'h0000_0500, 5'd0, 1'b0, 1'b0, 2);
      push_req("sw2", 1'b1, 32'h0000_0504, 32'hCAFE_F00D, 1'b1, 4'b1111, 1, 2);
      push_ret("sw2", 32'h0000_0504, 5'd0, 1'b0, 1'b0, 2);
      issue("sw1", 32'h0000_0500, 32'h1122_3344, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1, 32'h0);
      issue("sw2", 32'h0000_0504, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1, 32'h0);

      // Reset while BUSY, then a stray ack after release.
      resp_en = 1'b0;
      push_req("rst_busy", 1'b0, 32'h0000_0400, 32'h0, 1'b0, 4'b0000, -1, -1);
      drive(32'h0000_0400, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b010);
      repeat (3) @(posedge clock);
      #3;
      reset_n = 1'b0;
      bubble();
      #1;
      chk("rst_busy.dmem_req",  32'(dmem.dmem_req), 32'd0);
      chk("rst_busy.dmem_addr", dmem.dmem_addr,     32'd0);
      chk("rst_busy.stall",     32'(stall),         32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      dmem.dmem_ack   = 1'b1;
      dmem.dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clock);
      dmem.dmem_ack   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst.dmem_req",     32'(dmem.dmem_req),  32'd0);
         chk("post_rst.stall",        32'(stall),          32'd0);
         chk("post_rst.wb_reg_write", 32'(wb_reg_write),   32'd0);
         @(negedge clock);
      end
      resp_en = 1'b1;
      @(posedge clock); #1;
      push_ret("alu_after_rst", 32'h0000_ABCD, 5'd9, 1'b1, 1'b0, 0);
      issue("alu_after_rst", 32'h0000_ABCD, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000, 1, 32'h0);

      repeat (3) @(posedge clock);
      chk("req_queue_drained", 32'(req_q.size()), 32'd0);
      chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
